// File: rtl/jogador_automatico_if.sv
// Signal bundle between the automatic player and the Genius game / host.
// The slave modport is the player's view; the master modport drives it.
interface jogador_automatico_if;
    logic       iniciar;
    logic       escreve;
    logic [3:0] endereco_escrita;
    logic [3:0] dado_escrita;
    logic [3:0] num_rodadas;
    logic       erro_habilita;
    logic [3:0] erro_rodada;
    logic [3:0] erro_jogada;
    logic       pronto_jogo;
    logic       ganhou;
    logic       perdeu;
    logic [3:0] botoes;
    logic       iniciar_jogo;
    logic       ocupado;
    logic       fim;
    logic [3:0] db_rodada;
    logic [3:0] db_jogada;
    logic [3:0] db_estado;

    modport slave (
        input  iniciar, escreve, endereco_escrita, dado_escrita, num_rodadas,
        input  erro_habilita, erro_rodada, erro_jogada,
        input  pronto_jogo, ganhou, perdeu,
        output botoes, iniciar_jogo, ocupado, fim, db_rodada, db_jogada, db_estado
    );

    modport master (
        output iniciar, escreve, endereco_escrita, dado_escrita, num_rodadas,
        output erro_habilita, erro_rodada, erro_jogada,
        output pronto_jogo, ganhou, perdeu,
        input  botoes, iniciar_jogo, ocupado, fim, db_rodada, db_jogada, db_estado
    );
endinterface

// File: rtl/jogador_automatico.sv
// Automatic player for the Genius memory game: replays a stored sequence
// round by round, optionally injecting one wrong play at a chosen position.
module jogador_automatico #(
    parameter int START_LEN = 5,
    parameter int HOLD      = 5,
    parameter int GAP       = 5,
    parameter int ROUND_GAP = 5,
    parameter int CNT_W     = 12
) (
    input logic                  clock,
    input logic                  reset,
    jogador_automatico_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        WAIT_S  = 4'd2,
        PRESS   = 4'd3,
        RELEASE = 4'd4,
        RGAP    = 4'd5,
        DONE    = 4'd6
    } state_t;

    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_LEN - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] RGAP_LAST  = CNT_W'(ROUND_GAP - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       rodada;
    logic [3:0]       jogada;
    logic [3:0]       mem [16];
    logic             iniciar_q;
    logic [3:0]       botoes_r;
    logic             iniciar_jogo_r;
    logic             ocupado_r;
    logic             fim_r;

    logic             start;
    logic             abort_now;
    logic             idle_like;
    logic [3:0]       nxt_jogada;
    logic             inject;
    logic [3:0]       valor_next;

    // Wrong play: rotate-left, so a one-hot play becomes a different button.
    function automatic logic [3:0] play_value(input logic [3:0] word, input logic wrong);
        return wrong ? {word[2:0], word[3]} : word;
    endfunction

    assign start     = bus.iniciar & ~iniciar_q;
    assign idle_like = (state == IDLE) || (state == DONE);

    // The game still shows its previous pronto during START's first cycle.
    always_comb begin
        abort_now = 1'b0;
        if (bus.ganhou || bus.perdeu || bus.pronto_jogo) begin
            case (state)
                START:                         abort_now = (cnt != '0);
                WAIT_S, PRESS, RELEASE, RGAP:  abort_now = 1'b1;
                default:                       abort_now = 1'b0;
            endcase
        end
    end

    // The value is computed for the play about to enter PRESS, so botoes
    // is valid from the first PRESS cycle.
    assign nxt_jogada = (state == RELEASE) ? jogada + 4'd1 : jogada;
    assign inject     = bus.erro_habilita && (rodada == bus.erro_rodada) &&
                        (nxt_jogada == bus.erro_jogada);
    assign valor_next = play_value(mem[nxt_jogada], inject);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            rodada         <= 4'd0;
            jogada         <= 4'd0;
            iniciar_q      <= 1'b0;
            botoes_r       <= 4'd0;
            iniciar_jogo_r <= 1'b0;
            ocupado_r      <= 1'b0;
            fim_r          <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 4'd0;
            end
        end else begin
            iniciar_q <= bus.iniciar;

            if (idle_like && bus.escreve) begin
                mem[bus.endereco_escrita] <= bus.dado_escrita;
            end

            if (abort_now) begin
                state          <= DONE;
                cnt            <= '0;
                botoes_r       <= 4'd0;
                iniciar_jogo_r <= 1'b0;
                ocupado_r      <= 1'b0;
                fim_r          <= 1'b1;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            state          <= START;
                            cnt            <= '0;
                            rodada         <= 4'd0;
                            jogada         <= 4'd0;
                            botoes_r       <= 4'd0;
                            iniciar_jogo_r <= 1'b1;
                            ocupado_r      <= 1'b1;
                            fim_r          <= 1'b0;
                        end
                    end

                    START: begin
                        if (cnt == START_LAST) begin
                            state          <= WAIT_S;
                            cnt            <= '0;
                            iniciar_jogo_r <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    WAIT_S: begin
                        if (cnt == GAP_LAST) begin
                            state    <= PRESS;
                            cnt      <= '0;
                            botoes_r <= valor_next;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    PRESS: begin
                        if (cnt == HOLD_LAST) begin
                            state    <= RELEASE;
                            cnt      <= '0;
                            botoes_r <= 4'd0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    RELEASE: begin
                        if (cnt == GAP_LAST) begin
                            cnt <= '0;
                            if (jogada < rodada) begin
                                jogada   <= jogada + 4'd1;
                                state    <= PRESS;
                                botoes_r <= valor_next;
                            end else if ((rodada == bus.num_rodadas) || (rodada == 4'hF)) begin
                                // rodada saturates at 15 even if num_rodadas changes mid-run
                                state     <= DONE;
                                ocupado_r <= 1'b0;
                                fim_r     <= 1'b1;
                            end else begin
                                rodada <= rodada + 4'd1;
                                jogada <= 4'd0;
                                state  <= RGAP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    RGAP: begin
                        if (cnt == RGAP_LAST) begin
                            state    <= PRESS;
                            cnt      <= '0;
                            botoes_r <= valor_next;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end

                    default: begin
                        state          <= IDLE;
                        cnt            <= '0;
                        botoes_r       <= 4'd0;
                        iniciar_jogo_r <= 1'b0;
                        ocupado_r      <= 1'b0;
                        fim_r          <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.botoes       = botoes_r;
    assign bus.iniciar_jogo = iniciar_jogo_r;
    assign bus.ocupado      = ocupado_r;
    assign bus.fim          = fim_r;
    assign bus.db_rodada    = rodada;
    assign bus.db_jogada    = jogada;
    assign bus.db_estado    = state;

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico: expected start pulses and presses
// are queued by the stimulus; a monitor measures them and compares.
module tb_jogador_automatico;

    logic clock = 1'b0;
    logic reset = 1'b0;

    jogador_automatico_if bus_if ();

    jogador_automatico dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] val;
        int         hold;
        int         gap;
    } press_t;

    press_t press_q[$];
    int     start_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_press(input logic [3:0] v, input int h, input int g);
        press_t e;
        e.val  = v;
        e.hold = h;
        e.gap  = g;
        press_q.push_back(e);
    endtask

    // Monitor: measures each PRESS visit and each iniciar_jogo pulse.
    logic       in_press = 1'b0;
    logic [3:0] pval     = 4'd0;
    int         plen     = 0;
    int         gap_at   = 0;
    int         idle     = 0;
    int         stray    = 0;
    int         slen     = 0;
    logic       ij_prev  = 1'b0;

    always @(negedge clock) begin
        press_t e;
        if (bus_if.db_estado == 4'd3) begin
            if (!in_press) begin
                in_press = 1'b1;
                plen     = 0;
                pval     = bus_if.botoes;
                gap_at   = idle;
            end else if (bus_if.botoes != pval) begin
                stray++;
            end
            plen++;
        end else begin
            if (in_press) begin
                in_press = 1'b0;
                if (press_q.size() == 0) begin
                    chk("unexpected_press", 1, 0);
                end else begin
                    e = press_q.pop_front();
                    chk("press_val", int'(pval), int'(e.val));
                    chk("press_hold", plen, e.hold);
                    chk("press_gap", gap_at, e.gap);
                    chk("botoes_glitch", stray, 0);
                    stray = 0;
                end
                idle = 0;
            end
            if (bus_if.botoes != 4'd0) stray++;
            idle++;
        end
        if (bus_if.iniciar_jogo) begin
            slen++;
        end else if (ij_prev) begin
            if (start_q.size() == 0) chk("unexpected_start", 1, 0);
            else chk("start_len", slen, start_q.pop_front());
            slen = 0;
            idle = 1;
        end
        ij_prev = bus_if.iniciar_jogo;
    end

    task automatic wr(input logic [3:0] a, input logic [3:0] d);
        @(negedge clock);
        bus_if.escreve          = 1'b1;
        bus_if.endereco_escrita = a;
        bus_if.dado_escrita     = d;
        @(negedge clock);
        bus_if.escreve          = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clock);
        bus_if.iniciar = 1'b1;
        @(negedge clock);
        bus_if.iniciar = 1'b0;
    endtask

    task automatic wait_fim(input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clock);
            if (bus_if.fim) seen = 1'b1;
        end
        if (!seen) chk("wait_fim_timeout", 0, 1);
    endtask

    task automatic wait_press_round(input logic [3:0] rod, input int max);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clock);
            if (bus_if.db_estado == 4'd3 && bus_if.db_rodada == rod) seen = 1'b1;
        end
        if (!seen) chk("wait_press_timeout", 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus_if.iniciar          = 1'b0;
        bus_if.escreve          = 1'b0;
        bus_if.endereco_escrita = 4'd0;
        bus_if.dado_escrita     = 4'd0;
        bus_if.num_rodadas      = 4'd0;
        bus_if.erro_habilita    = 1'b0;
        bus_if.erro_rodada      = 4'd0;
        bus_if.erro_jogada      = 4'd0;
        bus_if.pronto_jogo      = 1'b0;
        bus_if.ganhou           = 1'b0;
        bus_if.perdeu           = 1'b0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_botoes", int'(bus_if.botoes), 0);
        chk("rst_iniciar_jogo", int'(bus_if.iniciar_jogo), 0);
        chk("rst_ocupado", int'(bus_if.ocupado), 0);
        chk("rst_fim", int'(bus_if.fim), 0);
        chk("rst_estado", int'(bus_if.db_estado), 0);
        chk("rst_rodada", int'(bus_if.db_rodada), 0);
        chk("rst_jogada", int'(bus_if.db_jogada), 0);
        reset = 1'b1;

        // Full run, three rounds
        wr(4'd0, 4'b0001);
        wr(4'd1, 4'b0010);
        wr(4'd2, 4'b0100);
        bus_if.num_rodadas = 4'd2;
        start_q.push_back(5);
        push_press(4'b0001, 5, 5);
        push_press(4'b0001, 5, 10);
        push_press(4'b0010, 5, 5);
        push_press(4'b0001, 5, 10);
        push_press(4'b0010, 5, 5);
        push_press(4'b0100, 5, 5);
        pulse_start();
        chk("run1_ocupado", int'(bus_if.ocupado), 1);
        wait_fim(400);
        chk("run1_estado", int'(bus_if.db_estado), 6);
        chk("run1_ocupado_done", int'(bus_if.ocupado), 0);
        chk("run1_botoes_done", int'(bus_if.botoes), 0);
        chk("run1_rodada", int'(bus_if.db_rodada), 2);
        chk("run1_jogada", int'(bus_if.db_jogada), 2);

        // Error injection at round 1 play 1, restart from DONE, gated write
        bus_if.erro_habilita = 1'b1;
        bus_if.erro_rodada   = 4'd1;
        bus_if.erro_jogada   = 4'd1;
        bus_if.num_rodadas   = 4'd1;
        start_q.push_back(5);
        push_press(4'b0001, 5, 5);
        push_press(4'b0001, 5, 10);
        push_press(4'b0100, 5, 5);
        pulse_start();
        chk("restart_estado", int'(bus_if.db_estado), 1);
        chk("restart_rodada", int'(bus_if.db_rodada), 0);
        chk("restart_fim", int'(bus_if.fim), 0);
        wr(4'd1, 4'b1000);
        wait_fim(300);
        chk("run2_estado", int'(bus_if.db_estado), 6);
        bus_if.erro_habilita = 1'b0;

        // Abort on perdeu during round 1
        bus_if.num_rodadas = 4'd2;
        start_q.push_back(5);
        push_press(4'b0001, 5, 5);
        push_press(4'b0001, 1, 10);
        pulse_start();
        wait_press_round(4'd1, 300);
        bus_if.perdeu = 1'b1;
        @(negedge clock);
        chk("abort_estado", int'(bus_if.db_estado), 6);
        chk("abort_botoes", int'(bus_if.botoes), 0);
        chk("abort_fim", int'(bus_if.fim), 1);
        bus_if.perdeu = 1'b0;
        repeat (60) @(negedge clock);
        chk("abort_stays_done", int'(bus_if.db_estado), 6);

        // Zero word (timeout path); pronto held into START's first cycle is ignored
        wr(4'd1, 4'b0000);
        bus_if.num_rodadas = 4'd1;
        start_q.push_back(5);
        push_press(4'b0001, 5, 5);
        push_press(4'b0001, 5, 10);
        push_press(4'b0000, 5, 5);
        @(negedge clock);
        bus_if.iniciar     = 1'b1;
        bus_if.pronto_jogo = 1'b1;
        @(negedge clock);
        bus_if.iniciar     = 1'b0;
        @(negedge clock);
        bus_if.pronto_jogo = 1'b0;
        chk("pronto_first_cycle_ignored", int'(bus_if.db_estado), 1);
        wait_fim(300);
        chk("run4_rodada", int'(bus_if.db_rodada), 1);

        // Reset mid-PRESS, then iniciar held high across reset release
        bus_if.num_rodadas = 4'd0;
        start_q.push_back(5);
        push_press(4'b0001, 1, 5);
        pulse_start();
        wait_press_round(4'd0, 100);
        #2;
        reset          = 1'b0;
        bus_if.iniciar = 1'b1;
        #1;
        chk("async_rst_botoes", int'(bus_if.botoes), 0);
        chk("async_rst_estado", int'(bus_if.db_estado), 0);
        chk("async_rst_ocupado", int'(bus_if.ocupado), 0);
        start_q.push_back(5);
        push_press(4'b0000, 5, 5);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wait_fim(200);
        repeat (60) @(negedge clock);
        chk("held_iniciar_one_run", int'(bus_if.db_estado), 6);
        chk("held_iniciar_fim", int'(bus_if.fim), 1);
        bus_if.iniciar = 1'b0;

        chk("press_q_left", press_q.size(), 0);
        chk("start_q_left", start_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
